// File: rtl/gpio_input_pkg.sv
// gpio_input_pkg: pin count, register map and CTRL layout shared by the GPIO input block
package gpio_input_pkg;
  localparam int NUM_GPIO = 38;
  localparam int HI_W = NUM_GPIO - 32;
  localparam logic [3:0] REG_IN_LO   = 4'h0;
  localparam logic [3:0] REG_IN_HI   = 4'h1;
  localparam logic [3:0] REG_RISE_LO = 4'h2;
  localparam logic [3:0] REG_RISE_HI = 4'h3;
  localparam logic [3:0] REG_FALL_LO = 4'h4;
  localparam logic [3:0] REG_FALL_HI = 4'h5;
  localparam logic [3:0] REG_PEND_LO = 4'h6;
  localparam logic [3:0] REG_PEND_HI = 4'h7;
  localparam logic [3:0] REG_CTRL    = 4'h8;
  localparam int CTRL_DIV_W    = 16;
  localparam int CTRL_FILT_BIT = 16;
  localparam int CTRL_W        = 17;
  typedef enum logic {WB_IDLE, WB_ACK} wb_state_e;
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
  function automatic logic [31:0] hi_word(input logic [NUM_GPIO-1:0] v);
    return {{(32-HI_W){1'b0}}, v[NUM_GPIO-1:32]};
  endfunction
endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: one pin's synchronizer, tick-sampled glitch filter and stable-value edge detect
module gpio_in_filter (
  input  logic clk,
  input  logic nrst,
  input  logic pin,
  input  logic filt_en,
  input  logic tick,
  input  logic flush,
  output logic stb,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, stb_q, stb_d;
  logic [2:0] smp_q, smp_d;
  // flush parks the samples on the current stable value so a mode change never fakes an edge
  always_comb begin
    smp_d = flush ? {3{stb_q}} : tick ? {smp_q[1:0], s2_q} : smp_q;
    stb_d = flush ? stb_q
          : !filt_en ? s2_q
          : (tick && (smp_d == 3'b000 || smp_d == 3'b111)) ? smp_d[0]
          : stb_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      smp_q <= 3'b000;
      stb_q <= 1'b0;
    end else begin
      s1_q  <= pin;
      s2_q  <= s1_q;
      smp_q <= smp_d;
      stb_q <= stb_d;
    end
  end
  assign stb  = stb_q;
  assign rise = stb_d & ~stb_q;
  assign fall = ~stb_d & stb_q;
endmodule

// File: rtl/gpio_input_control.sv
// gpio_input_control: Wishbone slave that synchronizes/filters 38 input pins and latches edge events
module gpio_input_control
  import gpio_input_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_sync_o,
  output logic                irq_o
);
  wb_state_e state_q;
  logic [3:0] idx;
  logic req, wr, tick, flush, irq_q, irq_d, unused_ok;
  logic [31:0] mask, rdata;
  logic [NUM_GPIO-1:0] m38, d38, rise, fall, pend_clr;
  logic [NUM_GPIO-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d, pend_q, pend_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CTRL_DIV_W-1:0] cnt_q, cnt_d;
  assign idx = wbs_adr_i[5:2];
  assign req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
  assign wr = req & wbs_we_i;
  assign mask = lane_mask(wbs_sel_i);
  assign unused_ok = &{1'b0, wbs_adr_i[1:0]};
  // lo/hi register pairs share one 38-bit view; odd offsets steer the lanes onto bits 37:32
  assign m38 = idx[0] ? {mask[HI_W-1:0], 32'h0} : {{HI_W{1'b0}}, mask};
  assign d38 = {wbs_dat_i[HI_W-1:0], wbs_dat_i};
  always_comb begin
    rise_en_d = (wr && idx[3:1] == REG_RISE_LO[3:1]) ? (rise_en_q & ~m38) | (d38 & m38) : rise_en_q;
    fall_en_d = (wr && idx[3:1] == REG_FALL_LO[3:1]) ? (fall_en_q & ~m38) | (d38 & m38) : fall_en_q;
    pend_clr  = (wr && idx[3:1] == REG_PEND_LO[3:1]) ? d38 & m38 : '0;
    pend_d    = (pend_q & ~pend_clr) | (rise & rise_en_q) | (fall & fall_en_q);
    ctrl_d    = (wr && idx == REG_CTRL) ? (ctrl_q & ~mask[CTRL_W-1:0]) | (wbs_dat_i[CTRL_W-1:0] & mask[CTRL_W-1:0]) : ctrl_q;
    flush     = ctrl_d != ctrl_q;
    tick      = ctrl_q[CTRL_FILT_BIT] && cnt_q == ctrl_q[CTRL_DIV_W-1:0];
    cnt_d     = (flush || tick || !ctrl_q[CTRL_FILT_BIT]) ? '0 : cnt_q + 1'b1;
    irq_d     = |pend_q;
  end
  always_comb begin
    rdata = '0;
    case (idx)
      REG_IN_LO:   rdata = gpio_sync_o[31:0];
      REG_IN_HI:   rdata = hi_word(gpio_sync_o);
      REG_RISE_LO: rdata = rise_en_q[31:0];
      REG_RISE_HI: rdata = hi_word(rise_en_q);
      REG_FALL_LO: rdata = fall_en_q[31:0];
      REG_FALL_HI: rdata = hi_word(fall_en_q);
      REG_PEND_LO: rdata = pend_q[31:0];
      REG_PEND_HI: rdata = hi_word(pend_q);
      REG_CTRL:    rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      default:     rdata = '0;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= WB_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      case (state_q)
        WB_IDLE: if (req) begin
          state_q   <= WB_ACK;
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= rdata;
        end
        default: begin
          state_q   <= WB_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
        end
      endcase
    end
  end
  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    gpio_in_filter u_filt (
      .clk     (clk),
      .nrst    (nrst),
      .pin     (gpio_in[i]),
      .filt_en (ctrl_q[CTRL_FILT_BIT]),
      .tick    (tick),
      .flush   (flush),
      .stb     (gpio_sync_o[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end
  assign irq_o = irq_q;
endmodule

// File: tb/tb_gpio_input_control.sv
// tb_gpio_input_control: directed stimulus checked against a cycle-level behavioural model
module tb_gpio_input_control;
  localparam logic [31:0] BASE = 32'h3000_0100;
  localparam logic [63:0] MASK = 64'h0000_003F_FFFF_FFFF;
  logic clk = 1'b0, nrst = 1'b1, stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, wdat = '0, rdat;
  logic ack, irq;
  logic [37:0] gpio_in = '0, gpio_sync;
  int checks = 0, errors = 0;
  logic [63:0] m_s1 = '0, m_s2 = '0, m_stb = '0, m_ren = '0, m_fen = '0, m_pend = '0, m_rd = '0;
  logic [63:0] m_smp [3] = '{default: '0};
  logic [16:0] m_ctrl = '0;
  int m_cnt = 0;
  logic m_irq = 1'b0, m_ack = 1'b0, m_rdv = 1'b0;

  always #5 clk = ~clk;

  gpio_input_control dut (
    .clk(clk), .nrst(nrst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .gpio_in(gpio_in), .gpio_sync_o(gpio_sync), .irq_o(irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] half(input logic [63:0] v, input bit hi);
    return hi ? v[63:32] : v[31:0];
  endfunction

  function automatic logic [31:0] m_read(input int ix);
    case (ix)
      0, 1: return half(m_stb, ix[0]);
      2, 3: return half(m_ren, ix[0]);
      4, 5: return half(m_fen, ix[0]);
      6, 7: return half(m_pend, ix[0]);
      8: return {15'b0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  // Model: registers as 64-bit lo/hi pairs, pins as whole vectors, filter as "three equal tick samples"
  initial forever begin : model
    logic [63:0] wm, wd, nstb, eq, clr, nren, nfen;
    logic [16:0] nctrl;
    logic acc, tick, flush;
    int ix;
    @(posedge clk or negedge nrst);
    if (!nrst) begin
      m_s1 = '0; m_s2 = '0; m_stb = '0; m_ren = '0; m_fen = '0; m_pend = '0; m_rd = '0;
      m_ctrl = '0; m_cnt = 0; m_irq = 1'b0; m_ack = 1'b0; m_rdv = 1'b0;
      foreach (m_smp[k]) m_smp[k] = '0;
    end else begin
      acc = stb && cyc && !m_ack && adr[31:6] == BASE[31:6];
      ix = int'(adr[5:2]);
      m_rd = m_read(ix);
      wm = '0;
      for (int b = 0; b < 4; b++) if (sel[b]) wm[(ix % 2) * 32 + b * 8 +: 8] = 8'hFF;
      wm = (acc && we) ? wm & MASK : '0;
      wd = {wdat, wdat};
      nren = (ix / 2 == 1) ? (m_ren & ~wm) | (wd & wm) : m_ren;
      nfen = (ix / 2 == 2) ? (m_fen & ~wm) | (wd & wm) : m_fen;
      clr = (ix / 2 == 3) ? wd & wm : '0;
      nctrl = (ix == 8) ? (m_ctrl & ~wm[16:0]) | (wdat[16:0] & wm[16:0]) : m_ctrl;
      tick = m_ctrl[16] && m_cnt == int'(m_ctrl[15:0]);
      flush = nctrl != m_ctrl;
      nstb = m_stb;
      if (flush) foreach (m_smp[k]) m_smp[k] = m_stb;
      else if (!m_ctrl[16]) nstb = m_s2;
      else if (tick) begin
        m_smp[2] = m_smp[1]; m_smp[1] = m_smp[0]; m_smp[0] = m_s2;
        eq = ~(m_smp[0] ^ m_smp[1]) & ~(m_smp[1] ^ m_smp[2]);
        nstb = (m_stb & ~eq) | (m_smp[0] & eq);
      end
      m_cnt = (flush || tick || !m_ctrl[16]) ? 0 : m_cnt + 1;
      m_irq = |m_pend;
      m_ack = acc;
      m_rdv = acc && !we;
      m_pend = (m_pend & ~clr) | (nstb & ~m_stb & m_ren) | (~nstb & m_stb & m_fen);
      m_stb = nstb; m_ren = nren; m_fen = nfen; m_ctrl = nctrl;
      m_s2 = m_s1; m_s1 = {26'b0, gpio_in};
    end
  end

  initial forever begin
    @(negedge clk);
    check("sync", {26'b0, gpio_sync}, m_stb);
    check("irq", irq, m_irq);
    check("ack", ack, m_ack);
    if (m_rdv) check("rdata", rdat, m_rd);
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w,
                      output logic [31:0] r, output bit got);
    adr = a; wdat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1; got = 0; r = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (ack) begin got = 1; r = rdat; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    bit got;
    xfer(BASE + 32'(off), 32'h0, 4'hF, 1'b0, r, got);
    check("rd_ack", got, 1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    bit got;
    xfer(BASE + 32'(off), d, s, 1'b1, r, got);
    check("wr_ack", got, 1);
  endtask

  initial begin
    logic [31:0] r;
    bit got;
    gpio_in = '1;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    rd(8'h00, r); check("in_lo_reset", r, 32'hFFFF_FFFF);
    rd(8'h04, r); check("in_hi_reset", r, 32'h3F);
    rd(8'h18, r); check("pend_lo_reset", r, 0);
    rd(8'h1C, r); check("pend_hi_reset", r, 0);
    check("irq_reset", irq, 0);
    // unfiltered path: three-edge latency to stb, one more to irq
    gpio_in = '0;
    repeat (5) @(negedge clk);
    wr(8'h08, 32'h1, 4'hF);
    gpio_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); check("sync0_e1", gpio_sync[0], 0);
    @(negedge clk); check("sync0_e2", gpio_sync[0], 1); check("irq_e2", irq, 0);
    @(negedge clk); check("irq_e3", irq, 1);
    rd(8'h18, r); check("pend_lo_rise0", r, 32'h1);
    wr(8'h18, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_cleared", irq, 0);
    rd(8'h18, r); check("pend_lo_cleared", r, 0);
    // set beats a same-cycle W1C
    wr(8'h08, 32'h11, 4'hF);
    gpio_in[4] = 1'b1;
    repeat (4) @(negedge clk);
    rd(8'h18, r); check("pend_lo_rise4", r, 32'h10);
    gpio_in[4] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[4] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(8'h18, 32'h10, 4'hF);
    rd(8'h18, r); check("pend_set_wins", r, 32'h10);
    wr(8'h18, 32'h10, 4'hF);
    rd(8'h18, r); check("pend_w1c4", r, 0);
    // byte lanes, unmapped offset, foreign address
    wr(8'h08, 32'hAAAA_5555, 4'b0011);
    rd(8'h08, r); check("rise_lo_lanes", r, 32'h0000_5555);
    rd(8'h3C, r); check("unmapped_3c", r, 0);
    xfer(32'h3000_0200, 32'h0, 4'hF, 1'b0, r, got);
    check("foreign_noack", got, 0);
    // filtered path, DIV=3
    wr(8'h14, 32'h20, 4'hF);
    wr(8'h20, 32'h0001_0003, 4'hF);
    rd(8'h20, r); check("ctrl_rb", r, 32'h0001_0003);
    gpio_in[37] = 1'b1;
    repeat (8) @(negedge clk);
    gpio_in[37] = 1'b0;
    repeat (20) @(negedge clk);
    check("pulse8_blocked", gpio_sync[37], 0);
    rd(8'h1C, r); check("pend_hi_pulse8", r, 0);
    gpio_in[37] = 1'b1;
    repeat (16) @(negedge clk);
    check("level16_passes", gpio_sync[37], 1);
    gpio_in[37] = 1'b0;
    repeat (20) @(negedge clk);
    check("level16_released", gpio_sync[37], 0);
    rd(8'h1C, r); check("pend_hi_fall37", r, 32'h20);
    check("irq_fall37", irq, 1);
    // reset while a read is being acknowledged
    adr = BASE; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #2;
    check("ack_before_rst", ack, 1);
    check("dat_before_rst", rdat, 32'h11);
    nrst = 1'b0;
    #1;
    check("ack_async_rst", ack, 0);
    check("dat_async_rst", rdat, 0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    rd(8'h08, r); check("rise_lo_after_rst", r, 0);
    rd(8'h14, r); check("fall_hi_after_rst", r, 0);
    rd(8'h1C, r); check("pend_hi_after_rst", r, 0);
    rd(8'h20, r); check("ctrl_after_rst", r, 0);
    check("irq_after_rst", irq, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
